// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if
// Requester-side bus of the register bank arbiter: two requesters share one
// request/response channel set, with per-requester valid/ready bits.
//
//   req_valid[1:0]   requester -> arbiter   request valid, bit i = requester i
//   req_ready[1:0]   arbiter -> requester   request accept
//   req_write[1:0]   requester -> arbiter   1 = write, 0 = read
//   req_addr0/1      requester -> arbiter   byte address
//   req_wdata0/1     requester -> arbiter   write data
//   rsp_valid[1:0]   arbiter -> requester   response valid, bit i = requester i
//   rsp_ready[1:0]   requester -> arbiter   response accept
//   rsp_data         arbiter -> requester   shared read data, qualified by rsp_valid
//   rsp_err          arbiter -> requester   shared error flag, qualified by rsp_valid
interface regbank_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // master = the requesters, slave = the arbiter
    modport master (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
// Arbitrates two requesters onto a single register bank, one transaction in
// flight at a time. Round-robin pointer breaks ties and only moves when a
// response completes. Register index is addr[5:2]; misaligned accesses and
// writes to the read-only index RO_IDX are flagged in rsp_err, and such
// writes never reach the bank.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active high
//   bus          requester channel (regbank_arbiter_if.slave)
//   write_en     bank write strobe, one cycle in EXEC
//   write_addr   bank write address (0 outside EXEC)
//   write_data   bank write data    (0 outside EXEC)
//   read_addr    bank read address  (0 outside EXEC)
//   read_data    bank combinational read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; winner sees req_ready this cycle
// EXEC  | captured transaction drives the bank; response registered
// RESP  | rsp_valid[id] held with stable data until rsp_ready[id]
module regbank_arbiter #(
    parameter int RO_IDX  = 3,
    parameter int NUM_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    regbank_arbiter_if.slave bus,
    output logic             write_en,
    output logic [31:0]      write_addr,
    output logic [31:0]      write_data,
    output logic [31:0]      read_addr,
    input  logic [31:0]      read_data
);

    localparam logic [3:0] RO_INDEX = 4'(RO_IDX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               ptr;
    logic               cap_id;
    logic               cap_write;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               cap_err;
    logic [NUM_REQ-1:0] grant;

    // Grant is only ever offered in IDLE, and never while reset is held.
    always_comb begin
        grant = '0;
        if (state == IDLE && !reset) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign cap_err = (cap_addr[1:0] != 2'b00) ||
                     (cap_write && (cap_addr[5:2] == RO_INDEX));

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP && !reset) ? (cap_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Bank side is quiet (all zero) outside EXEC.
    assign write_en   = (state == EXEC) && !reset && cap_write && !cap_err;
    assign write_addr = (state == EXEC) ? cap_addr  : 32'd0;
    assign write_data = (state == EXEC) ? cap_wdata : 32'd0;
    assign read_addr  = (state == EXEC) ? cap_addr  : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cap_id     <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != '0) begin
                        cap_id    <= grant[1];
                        cap_write <= bus.req_write[grant[1]];
                        cap_addr  <= grant[1] ? bus.req_addr1  : bus.req_addr0;
                        cap_wdata <= grant[1] ? bus.req_wdata1 : bus.req_wdata0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    // Reads return bank data even when misaligned; writes return 0.
                    rsp_data_q <= cap_write ? 32'd0 : read_data;
                    rsp_err_q  <= cap_err;
                    state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[cap_id]) begin
                        ptr   <= ~cap_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
